// File: rtl/pipe_result_fifo_pkg.sv
// Shared MCycle definitions: default result width, pointer/count width helpers
// and the up/down operation encoding used by the occupancy and credit counters.
package mcycle_pkg;

  localparam int unsigned MCYCLE_DATA_WIDTH = 32;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/pipe_result_fifo_credit_counter.sv
// Credit counter for pipeline launches: starts full, spent on issue, returned on pop.
// PIPE_RESULT_FIFO_OVF_CHECK_EN adds a simulation check that credits never exceed MAX.
module credit_counter
  import mcycle_pkg::*;
#(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic take,
  input  logic give,
  output logic ready
);

  localparam int unsigned CW = count_width(MAX);

  logic [CW-1:0] credits;
  cnt_op_e       op;

  always_comb begin
    op = CNT_HOLD;
    if (take && !give) begin
      op = CNT_DEC;
    end else if (give && !take) begin
      op = CNT_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CW'(MAX);
    end else begin
      case (op)
        CNT_INC: credits <= credits + CW'(1);
        CNT_DEC: credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  assign ready = (credits != '0);

`ifdef PIPE_RESULT_FIFO_OVF_CHECK_EN
  a_credit_bound: assert property (@(posedge clk) disable iff (rst) credits <= CW'(MAX))
    else $error("credit_counter: credits above MAX");
`endif

endmodule

// File: rtl/pipe_result_fifo.sv
// First-word-fall-through result FIFO with launch credits for the MCycle pipeline.
// PIPE_RESULT_FIFO_OVF_CHECK_EN enables the sticky ovf_err flag and overflow assertions.
module pipe_result_fifo
  import mcycle_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MCYCLE_DATA_WIDTH,
  parameter int unsigned PIPE_DEPTH = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic                               pipe_valid,
  input  logic [DATA_WIDTH-1:0]              pipe_data,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  input  logic                               out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                               ovf_err
);

  localparam int unsigned PW = ptr_width(FIFO_DEPTH);
  localparam int unsigned CW = count_width(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PIPE_DEPTH < 1) begin : g_param_check
    $error("pipe_result_fifo: FIFO_DEPTH must be a power of two >= 2 and PIPE_DEPTH >= 1");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  wr_en;
  logic                  issue_fire;
  cnt_op_e               occ_op;

  assign push       = pipe_valid;
  assign pop        = out_valid & out_ready;
  assign full       = (count == CW'(FIFO_DEPTH));
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign wr_en      = push & (~full | pop);
  assign issue_fire = issue_valid & issue_ready;

  assign out_valid  = (count != '0);
  assign out_data   = mem[rd_ptr];

  credit_counter #(
    .MAX (FIFO_DEPTH)
  ) u_credit_counter (
    .clk   (clk),
    .rst   (rst),
    .take  (issue_fire),
    .give  (pop),
    .ready (issue_ready)
  );

  always_comb begin
    occ_op = CNT_HOLD;
    if (wr_en && !pop) begin
      occ_op = CNT_INC;
    end else if (pop && !wr_en) begin
      occ_op = CNT_DEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case (occ_op)
        CNT_INC: count <= count + CW'(1);
        CNT_DEC: count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= pipe_data;
    end
  end

`ifdef PIPE_RESULT_FIFO_OVF_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (push && full && !pop) begin
      ovf_err <= 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
    else $error("pipe_result_fifo: push into full FIFO");
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_result_fifo.sv
// Self-checking bench for pipe_result_fifo against a queue-based reference model
// with a bench-side fixed-latency pipeline feeding pipe_valid/pipe_data.
module tb_pipe_result_fifo;

  localparam int DW = 32;
  localparam int PD = 4;
  localparam int FD = 8;
`ifdef PIPE_RESULT_FIFO_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  logic          pipe_valid;
  logic [DW-1:0] pipe_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [3:0]    count;
  logic          ovf_err;

  always #5 clk = ~clk;

  pipe_result_fifo #(
    .DATA_WIDTH (DW),
    .PIPE_DEPTH (PD),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .pipe_valid  (pipe_valid),
    .pipe_data   (pipe_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .ovf_err     (ovf_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO contents as a queue, credits as a plain integer.
  logic [DW-1:0] m_q[$];
  int            m_credits = FD;
  bit            m_ovf = 1'b0;
  bit            sh_v[PD];
  logic [DW-1:0] sh_d[PD];
  logic [DW-1:0] seq_word = '0;
  bit            rand_data = 1'b0;

  task automatic tick();
    bit            fire;
    bit            pop;
    bit            full;
    logic [DW-1:0] w;
    fire = issue_valid && (m_credits != 0);
    pop  = out_ready && (m_q.size() != 0);
    if (rst) begin
      m_q.delete();
      m_credits = FD;
      m_ovf     = 1'b0;
      for (int i = 0; i < PD; i++) sh_v[i] = 1'b0;
    end else begin
      full = (m_q.size() == FD);
      if (pipe_valid && full && !pop) m_ovf = OVF_EN;
      if (pop) void'(m_q.pop_front());
      if (pipe_valid && (!full || pop)) m_q.push_back(pipe_data);
      m_credits += (pop ? 1 : 0) - (fire ? 1 : 0);
      w = '0;
      if (fire) begin
        if (rand_data) w = $urandom;
        else begin
          seq_word = seq_word + 1;
          w = seq_word;
        end
      end
      for (int i = PD - 1; i > 0; i--) begin
        sh_v[i] = sh_v[i-1];
        sh_d[i] = sh_d[i-1];
      end
      sh_v[0] = fire;
      sh_d[0] = w;
    end
    @(posedge clk);
    #1;
    pipe_valid = sh_v[PD-1];
    pipe_data  = sh_d[PD-1];
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; pipe_valid = 1'b0; pipe_data = '0;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL reset_issue_ready c=%0d: got %b expected 1", c, issue_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid c=%0d: got %b expected 0", c, out_valid); end
      tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count c=%0d: got %0d expected 0", c, count); end
      tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL reset_ovf c=%0d: got %b expected 0", c, ovf_err); end
      tick();
    end
  endtask

  task automatic test_fill();
    int fires = 0;
    rand_data = 1'b0; seq_word = '0;
    issue_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < FD + PD + 4; c++) begin
      if (issue_valid && issue_ready) fires++;
      tests++; if (issue_ready !== (m_credits != 0)) begin fails++; $display("FAIL fill_issue_ready c=%0d: got %b expected %b", c, issue_ready, m_credits != 0); end
      tests++; if (count !== 4'(m_q.size())) begin fails++; $display("FAIL fill_count c=%0d: got %0d expected %0d", c, count, m_q.size()); end
      tick();
    end
    issue_valid = 1'b0;
    tests++; if (fires != FD) begin fails++; $display("FAIL fill_fires: got %0d expected %0d", fires, FD); end
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL fill_stall: got %b expected 0", issue_ready); end
    tests++; if (count !== 4'(FD)) begin fails++; $display("FAIL fill_full_count: got %0d expected %0d", count, FD); end
    tests++; if (out_data !== 32'h1) begin fails++; $display("FAIL fill_head: got %0h expected 1", out_data); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int i = 0; i < FD; i++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL drain_valid i=%0d: got %b expected 1", i, out_valid); end
      tests++; if (out_data !== DW'(i + 1)) begin fails++; $display("FAIL drain_data i=%0d: got %0h expected %0h", i, out_data, i + 1); end
      tick();
      if (i == 0) begin
        tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL drain_credit_return: got %b expected 1", issue_ready); end
      end
    end
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_stream();
    rand_data = 1'b1;
    issue_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (c >= 5) begin
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid c=%0d: got %b expected 1", c, out_valid); end
      end
      tests++; if (count > 4'd5) begin fails++; $display("FAIL stream_count_bound c=%0d: got %0d expected <=5", c, count); end
      tests++; if (count !== 4'(m_q.size())) begin fails++; $display("FAIL stream_count c=%0d: got %0d expected %0d", c, count, m_q.size()); end
      if (m_q.size() != 0) begin
        tests++; if (out_data !== m_q[0]) begin fails++; $display("FAIL stream_data c=%0d: got %0h expected %0h", c, out_data, m_q[0]); end
      end
      tick();
    end
    issue_valid = 1'b0;
    for (int c = 0; c < PD + 4; c++) tick();
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    rand_data = 1'b0; seq_word = '0;
    issue_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < FD + PD + 2; c++) tick();
    issue_valid = 1'b0;
    pipe_valid = 1'b1; pipe_data = 32'hA5A5_0009; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++; if (count !== 4'(FD)) begin fails++; $display("FAIL pp_full_count: got %0d expected %0d", count, FD); end
    tests++; if (out_data !== 32'h2) begin fails++; $display("FAIL pp_head_advance: got %0h expected 2", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < FD - 1; i++) begin
      tests++; if (out_data !== DW'(i + 2)) begin fails++; $display("FAIL pp_order i=%0d: got %0h expected %0h", i, out_data, i + 2); end
      tick();
    end
    out_ready = 1'b0;
    tests++; if (out_data !== 32'hA5A5_0009) begin fails++; $display("FAIL pp_new_word: got %0h expected a5a50009", out_data); end
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL pp_last_count: got %0d expected 1", count); end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_overflow();
    rand_data = 1'b0; seq_word = '0;
    issue_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < FD + PD + 2; c++) tick();
    issue_valid = 1'b0;
    pipe_valid = 1'b1; pipe_data = 32'hDEAD_BEEF;
    tick();
    tests++; if (ovf_err !== OVF_EN) begin fails++; $display("FAIL ovf_flag: got %b expected %b", ovf_err, OVF_EN); end
    tests++; if (count !== 4'(FD)) begin fails++; $display("FAIL ovf_count: got %0d expected %0d", count, FD); end
    tick();
    tests++; if (ovf_err !== m_ovf) begin fails++; $display("FAIL ovf_sticky: got %b expected %b", ovf_err, m_ovf); end
    out_ready = 1'b1;
    for (int i = 0; i < FD; i++) begin
      tests++; if (out_data !== DW'(i + 1)) begin fails++; $display("FAIL ovf_contents i=%0d: got %0h expected %0h", i, out_data, i + 1); end
      tick();
    end
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_dropped: got %b expected 0", out_valid); end
    rst = 1'b1; tick(); rst = 1'b0;
    tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL ovf_cleared: got %b expected 0", ovf_err); end
  endtask

  task automatic test_random();
    rand_data = 1'b1;
    for (int c = 0; c < 300; c++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      out_ready   = ($urandom_range(0, 3) != 0);
      rst         = (c == 150);
      tests++; if (issue_ready !== (m_credits != 0)) begin fails++; $display("FAIL rnd_issue_ready c=%0d: got %b expected %b", c, issue_ready, m_credits != 0); end
      tests++; if (out_valid !== (m_q.size() != 0)) begin fails++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, out_valid, m_q.size() != 0); end
      tests++; if (count !== 4'(m_q.size())) begin fails++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, count, m_q.size()); end
      tests++; if (ovf_err !== m_ovf) begin fails++; $display("FAIL rnd_ovf c=%0d: got %b expected %b", c, ovf_err, m_ovf); end
      if (m_q.size() != 0) begin
        tests++; if (out_data !== m_q[0]) begin fails++; $display("FAIL rnd_data c=%0d: got %0h expected %0h", c, out_data, m_q[0]); end
      end
      tick();
    end
    rst = 1'b0; issue_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < FD + PD + 2; c++) tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rnd_drained: got %b expected 0", out_valid); end
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL rnd_credits_back: got %b expected 1", issue_ready); end
  endtask

  initial begin
    for (int i = 0; i < PD; i++) begin sh_v[i] = 1'b0; sh_d[i] = '0; end
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_push_pop();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
